// File: rtl/eightbit_issue_unit_pkg.sv
// Shared definitions for the 8-bit issue unit and its ALU: op codes,
// instruction field positions and FSM state encoding.
package eightbit_issue_unit_pkg;

    localparam int OP_LSB = 13;
    localparam int RD_LSB = 10;
    localparam int RS_LSB = 7;
    localparam int RT_LSB = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_EQ  = 3'b110;
    localparam logic [2:0] OP_NE  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
    } fields_t;

    function automatic fields_t decode(input logic [15:0] word);
        fields_t f;
        f.op = word[OP_LSB +: 3];
        f.rd = word[RD_LSB +: 3];
        f.rs = word[RS_LSB +: 3];
        f.rt = word[RT_LSB +: 3];
        return f;
    endfunction

    // Compare ops only steer branch_taken and never write a register.
    function automatic logic is_compare(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/eightbit_regfile.sv
// 8x8 register file: two issue read ports, one debug read port, and a single
// write port where a writeback beats an external load to the same register.
module eightbit_regfile
    import eightbit_issue_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rs_addr,
    input  logic [2:0] rt_addr,
    output logic [7:0] rs_data,
    output logic [7:0] rt_data,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data,
    input  logic       wb_en,
    input  logic [2:0] wb_addr,
    input  logic [7:0] wb_data,
    input  logic       ld_en,
    input  logic [2:0] ld_addr,
    input  logic [7:0] ld_data
);

    logic [7:0] regs_reg [0:7];
    logic [7:0] wb_hit;
    logic [7:0] ld_hit;

    // R0 is hardwired: no hit line ever selects it.
    assign wb_hit[0] = 1'b0;
    assign ld_hit[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_hit
            assign wb_hit[gi] = wb_en && (wb_addr == 3'(gi));
            assign ld_hit[gi] = ld_en && (ld_addr == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_reg[i] <= 8'h00;
            end
        end else begin
            for (int i = 1; i < 8; i++) begin
                if (wb_hit[i]) begin
                    regs_reg[i] <= wb_data;
                end else if (ld_hit[i]) begin
                    regs_reg[i] <= ld_data;
                end
            end
        end
    end

    assign rs_data  = (rs_addr  == 3'd0) ? 8'h00 : regs_reg[rs_addr];
    assign rt_data  = (rt_addr  == 3'd0) ? 8'h00 : regs_reg[rt_addr];
    assign dbg_data = (dbg_addr == 3'd0) ? 8'h00 : regs_reg[dbg_addr];

endmodule

// File: rtl/eightbit_issue_unit.sv
// Three-state issue unit: latches operands for an external ALU, captures its
// result one cycle later and writes it back to the register file.
module eightbit_issue_unit
    import eightbit_issue_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [7:0]  ld_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_f,
    input  logic        alu_ovf,
    input  logic        alu_zero,
    output logic        done,
    output logic [7:0]  result,
    output logic        branch_taken,
    output logic        ovf_sticky,
    input  logic        clr_ovf,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    logic [1:0] state_reg;
    logic [2:0] rd_reg;
    logic [7:0] alu_a_reg;
    logic [7:0] alu_b_reg;
    logic [2:0] alu_sel_reg;
    logic [7:0] result_reg;
    logic       branch_reg;
    logic       ovf_reg;

    fields_t    fields;
    logic [7:0] rs_data;
    logic [7:0] rt_data;
    logic       accept;
    logic       wb_en;
    logic       unused_low_bits;

    assign fields          = decode(instr);
    assign unused_low_bits = ^instr[3:0];
    assign accept          = (state_reg == ST_IDLE) && instr_valid;
    assign wb_en           = (state_reg == ST_WB) && !is_compare(alu_sel_reg);

    eightbit_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (fields.rs),
        .rt_addr  (fields.rt),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_en    (wb_en),
        .wb_addr  (rd_reg),
        .wb_data  (result_reg),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rd_reg      <= 3'd0;
            alu_a_reg   <= 8'h00;
            alu_b_reg   <= 8'h00;
            alu_sel_reg <= 3'd0;
            result_reg  <= 8'h00;
            branch_reg  <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        rd_reg      <= fields.rd;
                        alu_a_reg   <= rs_data;
                        alu_b_reg   <= rt_data;
                        alu_sel_reg <= fields.op;
                        state_reg   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_reg <= alu_f;
                    if (is_compare(alu_sel_reg)) begin
                        branch_reg <= alu_zero;
                    end
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // A clear in the same cycle as an overflowing add wins.
            if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end else if ((state_reg == ST_EXEC) && (alu_sel_reg == OP_ADD) && alu_ovf) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign instr_ready  = (state_reg == ST_IDLE);
    assign done         = (state_reg == ST_WB);
    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_sel      = alu_sel_reg;
    assign result       = result_reg;
    assign branch_taken = branch_reg;
    assign ovf_sticky   = ovf_reg;

endmodule
